// File: rtl/lcrc_32_stream.sv
// Streaming PCIe LCRC-32 generator (CRC-32/ISO-HDLC over TLP beats, byte 0 first).
// Optional `LCRC_ERR_INJECT_EN adds inj_err to corrupt m_crc[0] of one packet.
module lcrc_32_stream #(
  parameter int          DATA_W = 32,
  parameter int          NB_W   = $clog2(DATA_W/8) + 1,
  parameter int          LEN_W  = 13,
  parameter logic [31:0] SEED   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sop,
  input  logic              s_eop,
  input  logic [NB_W-1:0]   s_nbytes,
`ifdef LCRC_ERR_INJECT_EN
  input  logic              inj_err,
`endif
  output logic              m_crc_valid,
  input  logic              m_crc_ready,
  output logic [31:0]       m_crc,
  output logic [LEN_W-1:0]  m_len,
  output logic              proto_err
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam logic [NB_W-1:0] NB_FULL = NB_W'(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The register is kept bit-reversed (LSB-first shifting with the reflected
  // polynomial), so the complement of it is already the bit-reversed result.
  localparam logic [31:0] SEED_R = rev32(SEED);

  function automatic logic [31:0] crc_beat(input logic [31:0] c_in,
                                           input logic [DATA_W-1:0] d,
                                           input logic [NB_W-1:0] n);
    logic [31:0] c;
    c = c_in;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (k < 32'(n)) begin
        for (int unsigned b = 0; b < 8; b++) begin
          c = (c[0] ^ d[8*k+b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  state_t            state_q, state_d, eff_state;
  logic [31:0]       crc_q, crc_d, crc_base, crc_upd;
  logic [LEN_W-1:0]  len_q, len_d, len_base, len_upd;
  logic [31:0]       mcrc_d;
  logic [LEN_W-1:0]  mlen_d;
  logic              perr_d;
  logic              acc, take, eop_bad;
  logic [NB_W-1:0]   n_eff;
  logic              inj;

`ifdef LCRC_ERR_INJECT_EN
  assign inj = inj_err;
`else
  assign inj = 1'b0;
`endif

  assign m_crc_valid = (state_q == DONE);
  assign s_ready     = reset & (!m_crc_valid | m_crc_ready);

  always_comb begin
    eff_state = state_q;
    if (state_q == DONE && m_crc_ready) eff_state = IDLE;

    acc      = s_valid & s_ready;
    eop_bad  = s_eop && ((s_nbytes == '0) || (s_nbytes > NB_FULL));
    n_eff    = (s_eop && !eop_bad) ? s_nbytes : NB_FULL;
    crc_base = s_sop ? SEED_R : crc_q;
    crc_upd  = crc_beat(crc_base, s_data, n_eff);
    len_base = s_sop ? '0 : len_q;
    len_upd  = len_base + LEN_W'(n_eff);
    take     = acc && (s_sop || eff_state == RUN);

    state_d = eff_state;
    crc_d   = crc_q;
    len_d   = len_q;
    mcrc_d  = m_crc;
    mlen_d  = m_len;
    perr_d  = 1'b0;

    if (acc) begin
      if (!take) begin
        perr_d = 1'b1;
      end else begin
        if ((s_sop && eff_state == RUN) || eop_bad) perr_d = 1'b1;
        crc_d = crc_upd;
        len_d = len_upd;
        if (s_eop) begin
          state_d = DONE;
          mcrc_d  = ~crc_upd ^ {31'b0, inj};
          mlen_d  = len_upd;
        end else begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      crc_q     <= '0;
      len_q     <= '0;
      m_crc     <= '0;
      m_len     <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      m_crc     <= mcrc_d;
      m_len     <= mlen_d;
      proto_err <= perr_d;
    end
  end

endmodule

// File: tb/tb_lcrc_32_stream.sv
// Directed self-checking bench for lcrc_32_stream (DATA_W=32).
module tb_lcrc_32_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_sop;
  logic        s_eop;
  logic [2:0]  s_nbytes;
  logic        m_crc_valid;
  logic        m_crc_ready;
  logic [31:0] m_crc;
  logic [12:0] m_len;
  logic        proto_err;
`ifdef LCRC_ERR_INJECT_EN
  logic        inj_err = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  lcrc_32_stream #(.DATA_W(32), .LEN_W(13), .SEED(32'hFFFF_FFFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sop       (s_sop),
    .s_eop       (s_eop),
    .s_nbytes    (s_nbytes),
`ifdef LCRC_ERR_INJECT_EN
    .inj_err     (inj_err),
`endif
    .m_crc_valid (m_crc_valid),
    .m_crc_ready (m_crc_ready),
    .m_crc       (m_crc),
    .m_len       (m_len),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Entered and left at a negedge; the beat is taken on the posedge in between.
  task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                           input logic [2:0] nb);
    int unsigned t = 0;
    s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop; s_nbytes = nb;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready got 0 expected 1");
    end
    @(negedge clk);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_nbytes = 3'd0; s_data = '0;
  endtask

  task automatic send_123456789();
    send_beat(32'h3433_3231, 1'b1, 1'b0, 3'd4);
    send_beat(32'h3837_3635, 1'b0, 1'b0, 3'd4);
    send_beat(32'h0000_0039, 1'b0, 1'b1, 3'd1);
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b0; s_data = '0; s_sop = 1'b0; s_eop = 1'b0;
    s_nbytes = 3'd0; m_crc_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, m_crc_valid, proto_err} !== 3'b000 || m_crc !== 32'h0 || m_len !== 13'h0) begin
      errors++;
      $display("FAIL reset_state: rdy/vld/perr=%b crc=%h len=%0d expected 000 0 0",
               {s_ready, m_crc_valid, proto_err}, m_crc, m_len);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_crc_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: s_ready=%b m_crc_valid=%b expected 1 0", s_ready, m_crc_valid);
    end
  endtask

  task automatic test_check_string();
    send_123456789();
    checks++;
    if (m_crc_valid !== 1'b1 || m_crc !== 32'hCBF4_3926 || m_len !== 13'd9 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL crc_123456789: vld=%b crc=%h len=%0d perr=%b expected 1 cbf43926 9 0",
               m_crc_valid, m_crc, m_len, proto_err);
    end
    @(negedge clk);
    checks++;
    if (m_crc_valid !== 1'b0) begin
      errors++;
      $display("FAIL crc_consumed: m_crc_valid=%b expected 0", m_crc_valid);
    end
  endtask

  task automatic test_single_beat();
    send_beat(32'h0, 1'b1, 1'b1, 3'd4);
    checks++;
    if (m_crc !== 32'h2144_DF1C || m_len !== 13'd4 || m_crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL zero4: crc=%h len=%0d vld=%b expected 2144df1c 4 1", m_crc, m_len, m_crc_valid);
    end
    send_beat(32'h0, 1'b1, 1'b1, 3'd1);
    checks++;
    if (m_crc !== 32'hD202_EF8D || m_len !== 13'd1) begin
      errors++;
      $display("FAIL zero1: crc=%h len=%0d expected d202ef8d 1", m_crc, m_len);
    end
    send_beat(32'h0, 1'b1, 1'b1, 3'd0);
    checks++;
    if (m_crc !== 32'h2144_DF1C || m_len !== 13'd4 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL nbytes0: crc=%h len=%0d perr=%b expected 2144df1c 4 1", m_crc, m_len, proto_err);
    end
    send_beat(32'h0, 1'b1, 1'b1, 3'd7);
    checks++;
    if (m_crc !== 32'h2144_DF1C || m_len !== 13'd4 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL nbytes7: crc=%h len=%0d perr=%b expected 2144df1c 4 1", m_crc, m_len, proto_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    m_crc_ready = 1'b0;
    send_beat(32'h0, 1'b1, 1'b1, 3'd4);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (s_ready !== 1'b0 || m_crc_valid !== 1'b1 || m_crc !== 32'h2144_DF1C) begin
        errors++;
        $display("FAIL hold_%0d: rdy=%b vld=%b crc=%h expected 0 1 2144df1c",
                 i, s_ready, m_crc_valid, m_crc);
      end
      @(negedge clk);
    end
    s_valid = 1'b1; s_data = 32'h0000_0061; s_sop = 1'b1; s_eop = 1'b1; s_nbytes = 3'd1;
    m_crc_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: s_ready=%b expected 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    checks++;
    if (m_crc_valid !== 1'b1 || m_crc !== 32'hE8B7_BE43 || m_len !== 13'd1) begin
      errors++;
      $display("FAIL b2b_second: vld=%b crc=%h len=%0d expected 1 e8b7be43 1",
               m_crc_valid, m_crc, m_len);
    end
    @(negedge clk);
  endtask

  task automatic test_proto_err();
    send_beat(32'h1122_3344, 1'b0, 1'b1, 3'd4);
    checks++;
    if (proto_err !== 1'b1 || m_crc_valid !== 1'b0) begin
      errors++;
      $display("FAIL nosop_idle: perr=%b vld=%b expected 1 0", proto_err, m_crc_valid);
    end
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0 || m_crc_valid !== 1'b0) begin
      errors++;
      $display("FAIL nosop_pulse: perr=%b vld=%b expected 0 0", proto_err, m_crc_valid);
    end
    send_beat(32'hDEAD_BEEF, 1'b1, 1'b0, 3'd4);
    send_beat(32'h3433_3231, 1'b1, 1'b0, 3'd4);
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL sop_in_run: proto_err=%b expected 1", proto_err);
    end
    send_beat(32'h3837_3635, 1'b0, 1'b0, 3'd4);
    send_beat(32'h0000_0039, 1'b0, 1'b1, 3'd1);
    checks++;
    if (m_crc !== 32'hCBF4_3926 || m_len !== 13'd9 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL restart_crc: crc=%h len=%0d perr=%b expected cbf43926 9 0", m_crc, m_len, proto_err);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    send_beat(32'h3433_3231, 1'b1, 1'b0, 3'd4);
    reset = 1'b0;
    s_valid = 1'b1; s_data = 32'h3837_3635;
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m_crc_valid !== 1'b0 || m_crc !== 32'h0) begin
      errors++;
      $display("FAIL midreset_clear: vld=%b crc=%h expected 0 0", m_crc_valid, m_crc);
    end
    send_beat(32'h0000_0061, 1'b1, 1'b1, 3'd1);
    checks++;
    if (m_crc !== 32'hE8B7_BE43 || m_len !== 13'd1 || m_crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_a: crc=%h len=%0d vld=%b expected e8b7be43 1 1", m_crc, m_len, m_crc_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_len_wrap();
    send_beat(32'h0, 1'b1, 1'b0, 3'd4);
    for (int i = 0; i < 2047; i++) send_beat(32'h0, 1'b0, 1'b0, 3'd4);
    send_beat(32'h0, 1'b0, 1'b1, 3'd4);
    checks++;
    if (m_len !== 13'd4 || proto_err !== 1'b0 || m_crc_valid !== 1'b1) begin
      errors++;
      $display("FAIL len_wrap: len=%0d perr=%b vld=%b expected 4 0 1", m_len, proto_err, m_crc_valid);
    end
    @(negedge clk);
  endtask

`ifdef LCRC_ERR_INJECT_EN
  task automatic test_inject();
    send_beat(32'h3433_3231, 1'b1, 1'b0, 3'd4);
    send_beat(32'h3837_3635, 1'b0, 1'b0, 3'd4);
    inj_err = 1'b1;
    send_beat(32'h0000_0039, 1'b0, 1'b1, 3'd1);
    inj_err = 1'b0;
    checks++;
    if (m_crc !== 32'hCBF4_3927) begin
      errors++;
      $display("FAIL inject: crc=%h expected cbf43927", m_crc);
    end
    @(negedge clk);
    send_123456789();
    checks++;
    if (m_crc !== 32'hCBF4_3926) begin
      errors++;
      $display("FAIL inject_next: crc=%h expected cbf43926", m_crc);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_check_string();
    test_single_beat();
    test_back_to_back();
    test_proto_err();
    test_mid_reset();
    test_len_wrap();
`ifdef LCRC_ERR_INJECT_EN
    test_inject();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
